commit_trace_encoder: RTL
=========================

// Module: commit_trace_encoder
// PURPOSE
// Synthesizable producer side of the commit trace path: captures retired instructions and exceptions
// from the CVA6 commit stage and buffers them in a FIFO. Serialises each event into a fixed 5-beat
// 32-bit valid/ready packet stream for an off-core trace sink or host-side log decoder.
// Sits beside the commit stage; adds no backpressure to the core (overflow drops and counts).
// PARAMETERS
// NrCommitPorts  2   commit ports sampled per cycle (encoder supports exactly 2)
// VLEN           64  PC/tval width; values <64 bits are zero-extended in packets
// DEPTH          8   FIFO entries, power of two, >=4
// PORTS
// clk_i          in   1          clock
// rst_i          in   1          asynchronous reset, active-high
// enable_i       in   1          capture enable; 0 = no new events captured
// commit_ack_i   in   2          per-port retire strobe
// commit_pc_i    in   2xVLEN     per-port PC
// commit_instr_i in   2x32       per-port instruction word
// we_i           in   2          per-port GPR/FPR write flag
// priv_lvl_i     in   2          current privilege level
// debug_mode_i   in   1          core in debug mode
// ex_valid_i     in   1          exception taken this cycle
// ex_cause_i     in   64         exception cause (low 32 bits sent)
// ex_tval_i      in   64         exception tval
// tdata_o        out  32         packet beat
// tvalid_o       out  1          beat valid
// tlast_o        out  1          last beat of packet (beat 4)
// tready_i       in   1          sink ready
// drop_cnt_o     out  16         events dropped on overflow, saturating at 0xFFFF
// BEHAVIOUR
// - Reset: FIFO empty, beat counter 0, seq 0, timestamp 0, lost flag 0; tvalid_o/tlast_o/tdata_o/drop_cnt_o = 0.
// - 32-bit free-running cycle timestamp, increments every cycle out of reset, wraps modulo 2^32.
// - Capture (enable_i=1): push order within a cycle: port0 commit, port1 commit, exception; up to 3 pushes/cycle.
// - Space = DEPTH - count at cycle start; a pop in the same cycle is not credited to pushes.
// - Events beyond free space are dropped in push order; drop_cnt_o += dropped count (saturating); lost flag set.
// - Lost flag copied into the next successfully pushed entry, then cleared. Drops in the same cycle re-set it
//   after that copy, so an earlier accepted event in the same cycle carries the prior flag.
// - Entry: type, priv, debug, lost, port, we, ts[31:0], A[63:0] (pc|tval), B[31:0] (instr|cause[31:0]).
// - Packet beats: 0 header, 1 ts, 2 A[31:0], 3 A[63:32], 4 B; tlast_o=1 on beat 4 only.
// - Header: [31:24]=8'hC7, [23:22] type (01 commit, 10 exception), [21:20] priv, [19] debug, [18] lost,
//   [17] port (0 for exceptions), [16] we (0 for exceptions), [15:0] seq.
// - seq is a 16-bit counter, +1 per completed packet, wraps 0xFFFF->0.
// - tvalid_o = FIFO non-empty; tdata_o combinational from FIFO head, beat counter and seq.
// - Latency: event at edge N into empty FIFO -> beat 0 valid in cycle N+1.
// - Handshake: beat advances on tvalid_o&tready_i; tdata_o/tlast_o stable while stalled.
// - Head entry popped and beat counter reset to 0 on the beat-4 handshake. Next packet may start the following cycle.
// - enable_i=0: nothing pushed, no drops counted; FIFO drains normally; a packet in flight always completes.
// - Async reset mid-packet: all state cleared immediately; the partial packet is abandoned (sink resyncs on 8'hC7).
// TESTING
// 1 Commit port0 pc=0x8000_0000 instr=0x13 we=1 priv=M, tready=1 -> beats C771_0000, ts, 8000_0000, 0, 0000_0013; tlast on beat 4.
// 2 Dual commit same cycle -> two packets: seq 0 port bit 0, then seq 1 port bit 1; 10 beats back-to-back.
// 3 tready=0 for 7 cycles with tvalid=1 -> tdata/tlast unchanged; release -> packet completes in 5 beats.
// 4 tready=0, dual commits for 5 cycles (DEPTH=8) -> 8 stored, drop_cnt_o=2; next accepted event header bit18=1, following 0.
// 5 Commit + ex_valid cause=2 tval=0xDEAD same cycle -> commit packet, then header type 10, A=0xDEAD, B=2.
// 6 rst_i during beat 2 -> tvalid_o=0 immediately, drop_cnt_o=0; first post-reset packet has seq 0.

Source files
------------

// File: rtl/commit_trace_encoder_if.sv
// Trace packet stream between the commit trace encoder and a trace sink.
//   tdata  : 32-bit packet beat
//   tvalid : beat valid
//   tlast  : last beat of a packet
//   tready : sink ready
// master = encoder side, slave = sink side.
interface commit_trace_encoder_if;
  logic [31:0] tdata;
  logic        tvalid;
  logic        tlast;
  logic        tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);
endinterface

// File: rtl/commit_trace_encoder.sv
// Commit trace encoder.
// Captures retired instructions (two commit ports) and exceptions from the
// commit stage into a small FIFO. Each buffered event is sent as a fixed
// 5-beat packet: header, timestamp, A[31:0], A[63:32], B. The core is never
// stalled: events that do not fit are dropped, counted, and flagged in the
// next accepted entry.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset
//   enable_i          capture enable (FIFO keeps draining when low)
//   commit_ack_i      per-port retire strobe
//   commit_pc_i       per-port PC (zero-extended to 64 bits)
//   commit_instr_i    per-port instruction word
//   we_i              per-port register write flag
//   priv_lvl_i        current privilege level
//   debug_mode_i      core in debug mode
//   ex_valid_i        exception taken this cycle
//   ex_cause_i        exception cause (low 32 bits are sent)
//   ex_tval_i         exception tval
//   trace             packet stream (master side)
//   drop_cnt_o        saturating count of dropped events
module commit_trace_encoder #(
  parameter int unsigned NrCommitPorts = 2,
  parameter int unsigned VLEN          = 64,
  parameter int unsigned DEPTH         = 8
) (
  input  logic                                clk_i,
  input  logic                                rst_i,
  input  logic                                enable_i,
  input  logic [NrCommitPorts-1:0]            commit_ack_i,
  input  logic [NrCommitPorts-1:0][VLEN-1:0]  commit_pc_i,
  input  logic [NrCommitPorts-1:0][31:0]      commit_instr_i,
  input  logic [NrCommitPorts-1:0]            we_i,
  input  logic [1:0]                          priv_lvl_i,
  input  logic                                debug_mode_i,
  input  logic                                ex_valid_i,
  input  logic [63:0]                         ex_cause_i,
  input  logic [63:0]                         ex_tval_i,
  commit_trace_encoder_if.master              trace,
  output logic [15:0]                         drop_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned NR_EV = 3;  // port0 commit, port1 commit, exception

  // Beat index within a packet.
  localparam logic [2:0] BEAT_HDR = 3'd0;
  localparam logic [2:0] BEAT_TS  = 3'd1;
  localparam logic [2:0] BEAT_ALO = 3'd2;
  localparam logic [2:0] BEAT_AHI = 3'd3;
  localparam logic [2:0] BEAT_B   = 3'd4;

  localparam logic [1:0] TYPE_COMMIT = 2'b01;
  localparam logic [1:0] TYPE_EXC    = 2'b10;

  typedef struct packed {
    logic [1:0]  typ;
    logic [1:0]  priv;
    logic        debug;
    logic        lost;
    logic        port;
    logic        we;
    logic [31:0] ts;
    logic [63:0] a;   // pc or tval
    logic [31:0] b;   // instr or cause[31:0]
  } entry_t;

  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic [2:0]         beat_q;
  logic [15:0]        seq_q;
  logic [31:0]        ts_q;
  logic               lost_q;
  logic [15:0]        drop_q;

  // Only the low half of the cause travels in the packet.
  logic unused_cause_hi;
  assign unused_cause_hi = ^ex_cause_i[63:32];

  // Candidate events for this cycle, already in push order.
  logic [NR_EV-1:0] ev_valid;
  entry_t           ev_entry [NR_EV];

  // NOTE: every signal written in an always_comb gets a default first, so no latch is inferred.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      ev_valid[i] = enable_i & commit_ack_i[i];
      ev_entry[i] = '{typ: TYPE_COMMIT, priv: priv_lvl_i, debug: debug_mode_i, lost: 1'b0,
                      port: 1'(i), we: we_i[i], ts: ts_q,
                      a: 64'(commit_pc_i[i]), b: commit_instr_i[i]};
    end
    ev_valid[2] = enable_i & ex_valid_i;
    ev_entry[2] = '{typ: TYPE_EXC, priv: priv_lvl_i, debug: debug_mode_i, lost: 1'b0,
                    port: 1'b0, we: 1'b0, ts: ts_q,
                    a: ex_tval_i, b: ex_cause_i[31:0]};
  end

  // Admission: free space is measured at cycle start (a pop this cycle does
  // not make room). Events are taken in order until space runs out; the rest
  // drop. The pending lost flag goes into the first accepted entry, and any
  // later drop re-arms it for the next cycle.
  logic [CNT_W-1:0] space;
  logic [1:0]       n_push, n_drop;
  logic             lost_d;
  logic [NR_EV-1:0] push_en;
  logic [PTR_W-1:0] push_idx   [NR_EV];
  entry_t           push_entry [NR_EV];

  // NOTE: blocking assignments in combinational logic; the loop depends on
  // seeing n_push and lost_d updated by earlier iterations.
  always_comb begin
    space   = CNT_W'(DEPTH) - count_q;
    n_push  = '0;
    n_drop  = '0;
    lost_d  = lost_q;
    push_en = '0;
    for (int i = 0; i < NR_EV; i++) begin
      push_idx[i]   = wr_ptr_q;
      push_entry[i] = ev_entry[i];
      if (ev_valid[i]) begin
        if (CNT_W'(n_push) < space) begin
          push_en[i]         = 1'b1;
          push_idx[i]        = wr_ptr_q + PTR_W'(n_push);
          push_entry[i].lost = lost_d;
          lost_d             = 1'b0;
          n_push             = n_push + 2'd1;
        end else begin
          n_drop = n_drop + 2'd1;
          lost_d = 1'b1;
        end
      end
    end
  end

  logic        handshake, pop;
  logic [16:0] drop_sum;
  logic [15:0] drop_d;

  assign handshake = trace.tvalid & trace.tready;
  assign pop       = handshake & (beat_q == BEAT_B);
  assign drop_sum  = {1'b0, drop_q} + 17'(n_drop);
  assign drop_d    = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];

  // NOTE: sequential state is updated with non-blocking assignments only.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      beat_q   <= BEAT_HDR;
      seq_q    <= '0;
      ts_q     <= '0;
      lost_q   <= 1'b0;
      drop_q   <= '0;
    end else begin
      ts_q     <= ts_q + 32'd1;
      wr_ptr_q <= wr_ptr_q + PTR_W'(n_push);
      rd_ptr_q <= rd_ptr_q + PTR_W'(pop);
      count_q  <= count_q + CNT_W'(n_push) - CNT_W'(pop);
      lost_q   <= lost_d;
      drop_q   <= drop_d;
      if (handshake) begin
        beat_q <= (beat_q == BEAT_B) ? BEAT_HDR : beat_q + 3'd1;
      end
      if (pop) begin
        seq_q <= seq_q + 16'd1;
      end
    end
  end

  // NOTE: the storage array has no reset; count_q alone says which slots hold
  // live data, so clearing the pointers is enough.
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < NR_EV; i++) begin
      if (push_en[i]) begin
        mem[push_idx[i]] <= push_entry[i];
      end
    end
  end

  // Packet serialisation from the FIFO head.
  entry_t      head;
  logic [31:0] beat_data;

  assign head = mem[rd_ptr_q];

  always_comb begin
    beat_data = '0;
    case (beat_q)
      BEAT_HDR: beat_data = {8'hC7, head.typ, head.priv, head.debug, head.lost,
                             head.port, head.we, seq_q};
      BEAT_TS:  beat_data = head.ts;
      BEAT_ALO: beat_data = head.a[31:0];
      BEAT_AHI: beat_data = head.a[63:32];
      BEAT_B:   beat_data = head.b;
      default:  beat_data = '0;
    endcase
  end

  assign trace.tvalid = (count_q != '0);
  assign trace.tlast  = trace.tvalid & (beat_q == BEAT_B);
  // Masked while empty so an unwritten head never reaches the sink.
  assign trace.tdata  = trace.tvalid ? beat_data : 32'h0;
  assign drop_cnt_o   = drop_q;

endmodule
